// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and default constants for the round-robin stream arbiter.
//   arb_state_e      : arbiter FSM state (IDLE while picking, LOCKED while a
//                      requester owns the shared stream)
//   DEF_*            : default values for the arbiter parameters
//   BEAT_CNT_W       : width of the per-packet beat counter (MAX_BEATS <= 255)
//   PKT_CNT_W        : width of the completed-packet counter
// -----------------------------------------------------------------------------
package stream_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BEATS  = 16;

  localparam int BEAT_CNT_W = 8;
  localparam int PKT_CNT_W  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage : stream_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Starting at (last_i + 1) mod NUM_REQ
// and wrapping around, returns the first index whose request bit is set.
//   req_i   : request vector
//   last_i  : index of the most recent winner
//   found_o : at least one request bit is set
//   idx_o   : winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Offset NUM_REQ lands back on the last winner, so it only wins when it
    // is the sole requester.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// Packet-level round-robin arbiter: NUM_REQ valid/ready streams share one
// output stream. A requester keeps the stream from its first beat until a
// beat with out_last transfers; packets longer than MAX_BEATS are cut with a
// forced last beat and a one-cycle overrun pulse.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/ready/last   : per-requester handshake and end-of-packet
//   in_data               : requester k payload at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/ready/data/last : shared output stream
//   grant_valid           : a requester currently owns the stream
//   grant_idx             : current or most recent owner
//   overrun               : pulses the cycle after a forced release
//   pkt_count             : completed packets, wrapping
// -----------------------------------------------------------------------------
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_BEATS  = DEF_MAX_BEATS,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          overrun,
  output logic [PKT_CNT_W-1:0]          pkt_count
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0]      LAST_REQ  = IDX_W'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic                    overrun_q, overrun_d;

  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic                    locked;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (in_valid),
    .last_i  (last_grant_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Granted requester's inputs, selected by comparison so that a grant index
  // never exceeds the populated lanes for non-power-of-two NUM_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q == IDX_W'(k)) begin
        sel_valid = in_valid[k];
        sel_last  = in_last[k];
        sel_data  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (locked && grant_q == IDX_W'(k)) in_ready[k] = out_ready;
    end
  end

  // The data path is combinational while LOCKED and forced to zero in IDLE,
  // which makes the arbitration cycle a bubble and keeps outputs at zero
  // during reset.
  assign locked      = (state_q == LOCKED);
  assign out_valid   = locked & sel_valid;
  assign out_data    = locked ? sel_data : '0;
  assign out_last    = locked & (sel_last | (beat_cnt_q == LAST_BEAT));
  assign xfer        = out_valid & out_ready;
  assign grant_valid = locked;
  assign grant_idx   = grant_q;
  assign overrun     = overrun_q;
  assign pkt_count   = pkt_cnt_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    overrun_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // A requester dropping in_valid simply stalls here; only a
        // transferred last beat releases the stream.
        if (xfer) begin
          if (out_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            pkt_cnt_d    = pkt_cnt_q + 1'b1;
            overrun_d    = ~sel_last;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_REQ;
      beat_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule : stream_rr_arbiter

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Self-checking bench for stream_rr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BEATS=16). Per-requester source queues feed the inputs; each scenario
// pushes the beats it expects on the shared output into a scoreboard, and a
// negedge monitor pops and compares every accepted output beat.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } src_beat_t;

  typedef struct {
    logic [1:0]    idx;
    logic [DW-1:0] data;
    logic          last;
    logic          forced;
  } exp_beat_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    in_valid = '0;
  logic [NR-1:0]    in_ready;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR-1:0]    in_last = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic             overrun;
  logic [15:0]      pkt_count;

  int checks = 0;
  int errors = 0;

  src_beat_t     src_q[NR][$];
  exp_beat_t     sb[$];
  logic [NR-1:0] pause = '0;
  logic [NR-1:0] hs = '0;
  logic          toggle_ready = 1'b0;
  logic [15:0]   exp_pkt = '0;
  logic          ovr_exp = 1'b0;
  int            ovr_seen = 0;
  int            acc_count = 0;
  int            idle_run = 0;
  logic          prev_gv = 1'b0;
  int            grant_log[$];
  int            gap_log[$];
  exp_beat_t     e;
  logic [NR-1:0] exp_rdy;

  stream_rr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .overrun     (overrun),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  // Present each requester's head beat unless it is paused.
  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0 && !pause[k]) begin
        in_valid[k]          = 1'b1;
        in_data[k*DW +: DW]  = src_q[k][0].data;
        in_last[k]           = src_q[k][0].last;
      end else begin
        in_valid[k]          = 1'b0;
        in_data[k*DW +: DW]  = '0;
        in_last[k]           = 1'b0;
      end
    end
  endtask

  task automatic add_src(input int k, input logic [DW-1:0] d, input logic l);
    src_q[k].push_back('{data: d, last: l});
  endtask

  task automatic add_exp(input int k, input logic [DW-1:0] d, input logic l,
                         input logic f);
    sb.push_back('{idx: 2'(k), data: d, last: l, forced: f});
  endtask

  function automatic bit srcs_empty();
    for (int k = 0; k < NR; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Pop accepted source beats just after each edge and refresh the inputs.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k] && src_q[k].size() > 0) src_q[k].delete(0);
    end
    if (toggle_ready) out_ready = ~out_ready;
    drive();
  end

  // Monitor: sample away from the rising edge and score every output beat.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pkt = '0;
      ovr_exp = 1'b0;
    end
    checks++;
    if (pkt_count !== exp_pkt) begin
      errors++;
      $display("FAIL pkt_count: got %0d, expected %0d at %0t", pkt_count, exp_pkt, $time);
    end
    checks++;
    if (overrun !== ovr_exp) begin
      errors++;
      $display("FAIL overrun: got %b, expected %b at %0t", overrun, ovr_exp, $time);
    end
    if (overrun === 1'b1) ovr_seen++;
    ovr_exp = 1'b0;
    hs = in_valid & in_ready;
    if (grant_valid !== 1'b1) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== '0) begin
        errors++;
        $display("FAIL idle_outputs: got out_valid=%b in_ready=%b, expected 0/0 at %0t",
                 out_valid, in_ready, $time);
      end
      idle_run++;
    end else begin
      if (!prev_gv) begin
        grant_log.push_back(int'(grant_idx));
        gap_log.push_back(idle_run);
      end
      idle_run = 0;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got grant to %0d, expected no grant at %0t",
                 grant_idx, $time);
      end else begin
        e = sb[0];
        checks++;
        if (grant_idx !== e.idx) begin
          errors++;
          $display("FAIL grant_idx: got %0d, expected %0d at %0t", grant_idx, e.idx, $time);
        end
        exp_rdy = '0;
        exp_rdy[e.idx] = out_ready;
        checks++;
        if (in_ready !== exp_rdy) begin
          errors++;
          $display("FAIL in_ready: got %b, expected %b at %0t", in_ready, exp_rdy, $time);
        end
        checks++;
        if (out_valid !== in_valid[e.idx]) begin
          errors++;
          $display("FAIL out_valid: got %b, expected %b at %0t", out_valid, in_valid[e.idx], $time);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          sb.delete(0);
          acc_count++;
          checks++;
          if (out_data !== e.data) begin
            errors++;
            $display("FAIL out_data: got %h, expected %h at %0t", out_data, e.data, $time);
          end
          checks++;
          if (out_last !== e.last) begin
            errors++;
            $display("FAIL out_last: got %b, expected %b (data %h) at %0t",
                     out_last, e.last, e.data, $time);
          end
          if (e.last) exp_pkt = exp_pkt + 16'd1;
          ovr_exp = e.forced;
        end
      end
    end
    prev_gv = (grant_valid === 1'b1);
  end

  task automatic apply_reset();
    reset_n      = 1'b0;
    for (int k = 0; k < NR; k++) src_q[k].delete();
    sb.delete();
    pause        = '0;
    toggle_ready = 1'b0;
    out_ready    = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    grant_log.delete();
    gap_log.delete();
    ovr_seen  = 0;
    acc_count = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(sb.size() == 0 && srcs_empty() && grant_valid === 1'b0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding after %0d cycles, expected 0",
               name, sb.size(), budget);
    end
  endtask

  task automatic wait_sb(input string name, input int left, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (sb.size() > left && n < budget);
    checks++;
    if (sb.size() > left) begin
      errors++;
      $display("FAIL %s_wait: got %0d beats outstanding, expected %0d", name, sb.size(), left);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_last, grant_valid, overrun} !== '0 ||
        out_data !== '0 || grant_idx !== '0 || pkt_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%b l=%b gv=%b ov=%b d=%h gi=%0d pc=%0d, expected all 0",
               out_valid, in_ready, out_last, grant_valid, overrun, out_data, grant_idx, pkt_count);
    end
    apply_reset();
  endtask

  task automatic test_single_packet();
    apply_reset();
    @(posedge clk);
    #2;
    add_src(0, 8'h11, 1'b0); add_exp(0, 8'h11, 1'b0, 1'b0);
    add_src(0, 8'h22, 1'b0); add_exp(0, 8'h22, 1'b0, 1'b0);
    add_src(0, 8'h33, 1'b1); add_exp(0, 8'h33, 1'b1, 1'b0);
    drive();
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble: got grant_valid=%b out_valid=%b, expected 0/0",
               grant_valid, out_valid);
    end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_grant: got grant_valid=%b idx=%0d, expected 1/0",
               grant_valid, grant_idx);
    end
    wait_drain("single", 50);
    checks++;
    if (pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL single_pkt_count: got %0d, expected 1", pkt_count);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    apply_reset();
    @(posedge clk);
    #2;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NR; k++) begin
        add_src(k, 8'(16 * k + p), 1'b1);
        add_exp(k, 8'(16 * k + p), 1'b1, 1'b0);
      end
    end
    drive();
    wait_drain("rr", 100);
    checks++;
    if (grant_log.size() != 8) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d, expected 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (grant_log[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, grant_log[i], exp_order[i]);
        end
        if (i > 0) begin
          checks++;
          if (gap_log[i] != 1) begin
            errors++;
            $display("FAIL rr_gap[%0d]: got %0d idle cycles, expected 1", i, gap_log[i]);
          end
        end
      end
    end
    checks++;
    if (pkt_count !== 16'd8) begin
      errors++;
      $display("FAIL rr_pkt_count: got %0d, expected 8", pkt_count);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    @(posedge clk);
    #2;
    // 20 beats from requester 2; the 16th is cut, the tail is a second packet.
    for (int b = 1; b <= 20; b++) add_src(2, 8'(8'h80 + b), (b == 20));
    add_src(3, 8'hC3, 1'b1);
    for (int b = 1; b <= 16; b++) add_exp(2, 8'(8'h80 + b), (b == 16), (b == 16));
    add_exp(3, 8'hC3, 1'b1, 1'b0);
    for (int b = 17; b <= 20; b++) add_exp(2, 8'(8'h80 + b), (b == 20), 1'b0);
    drive();
    wait_drain("overrun", 200);
    checks++;
    if (ovr_seen != 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d, expected 1", ovr_seen);
    end
    checks++;
    if (pkt_count !== 16'd3) begin
      errors++;
      $display("FAIL overrun_pkt_count: got %0d, expected 3", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(posedge clk);
    #2;
    for (int b = 0; b < 4; b++) begin
      add_src(1, 8'(8'h50 + b), (b == 3));
      add_exp(1, 8'(8'h50 + b), (b == 3), 1'b0);
    end
    toggle_ready = 1'b1;
    drive();
    wait_drain("bp", 100);
    toggle_ready = 1'b0;
    out_ready    = 1'b1;
    checks++;
    if (acc_count != 4) begin
      errors++;
      $display("FAIL bp_handshakes: got %0d, expected 4", acc_count);
    end
    checks++;
    if (pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_pkt_count: got %0d, expected 1", pkt_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    @(posedge clk);
    #2;
    for (int b = 0; b < 4; b++) begin
      add_src(0, 8'(8'h40 + b), (b == 3));
      add_exp(0, 8'(8'h40 + b), (b == 3), 1'b0);
    end
    drive();
    wait_sb("midrst", 2, 50);
    reset_n = 1'b0;
    for (int k = 0; k < NR; k++) src_q[k].delete();
    sb.delete();
    add_src(3, 8'h63, 1'b1);
    add_src(0, 8'h60, 1'b1);
    add_exp(0, 8'h60, 1'b1, 1'b0);
    add_exp(3, 8'h63, 1'b1, 1'b0);
    drive();
    #1;
    checks++;
    if ({out_valid, in_ready, out_last, grant_valid, overrun} !== '0 ||
        out_data !== '0 || grant_idx !== '0 || pkt_count !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got v=%b r=%b l=%b gv=%b ov=%b d=%h gi=%0d pc=%0d, expected all 0",
               out_valid, in_ready, out_last, grant_valid, overrun, out_data, grant_idx, pkt_count);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    wait_drain("midrst", 50);
    checks++;
    if (grant_log.size() == 0 || grant_log[grant_log.size() - 2 >= 0 ? grant_log.size() - 2 : 0] != 0) begin
      errors++;
      $display("FAIL midrst_first_grant: got log size %0d, expected first post-reset grant 0",
               grant_log.size());
    end
    checks++;
    if (pkt_count !== 16'd2) begin
      errors++;
      $display("FAIL midrst_pkt_count: got %0d, expected 2", pkt_count);
    end
  endtask

  task automatic test_drop_valid();
    apply_reset();
    @(posedge clk);
    #2;
    for (int b = 0; b < 4; b++) begin
      add_src(1, 8'(8'h70 + b), (b == 3));
      add_exp(1, 8'(8'h70 + b), (b == 3), 1'b0);
    end
    add_src(3, 8'hE3, 1'b1);
    add_exp(3, 8'hE3, 1'b1, 1'b0);
    drive();
    wait_sb("drop", 3, 50);
    pause[1] = 1'b1;
    drive();
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold: got gv=%b idx=%0d out_valid=%b, expected 1/1/0",
                 grant_valid, grant_idx, out_valid);
      end
    end
    @(posedge clk);
    #2;
    pause[1] = 1'b0;
    drive();
    wait_drain("drop", 60);
    checks++;
    if (pkt_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_pkt_count: got %0d, expected 2", pkt_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_overrun();
    test_backpressure();
    test_reset_mid_packet();
    test_drop_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stream_rr_arbiter
